// File: rtl/seg7_display_unit.sv
// Seven-segment output stage: converts a captured word to three decimal digits
// with a sequential double-dabble, then formats sign/blanking/overflow onto the displays.
module seg7_display_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter bit SIGNED_MODE = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  out_strobe,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  busy,
    output logic [6:0]            outputA,
    output logic [6:0]            outputB,
    output logic [6:0]            outputC
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    localparam logic signed [DATA_WIDTH:0] MAX_VAL = (DATA_WIDTH+1)'(999);
    localparam logic signed [DATA_WIDTH:0] MIN_VAL = (DATA_WIDTH+1)'(-99);

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              iter_cnt;
    logic                    pend_vld;
    logic [DATA_WIDTH-1:0]   pend_data;
    logic [21:0]             sr;
    logic                    neg;
    logic                    ovf;
    logic                    start;
    logic                    to_pend;
    logic [DATA_WIDTH-1:0]   start_word;
    logic [11:0]             cls;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_seg = 7'b1000000;
            4'd1:    digit_seg = 7'b1111001;
            4'd2:    digit_seg = 7'b0100100;
            4'd3:    digit_seg = 7'b0110000;
            4'd4:    digit_seg = 7'b0011001;
            4'd5:    digit_seg = 7'b0010010;
            4'd6:    digit_seg = 7'b0000010;
            4'd7:    digit_seg = 7'b1111000;
            4'd8:    digit_seg = 7'b0000000;
            4'd9:    digit_seg = 7'b0010000;
            default: digit_seg = SEG_BLANK;
        endcase
    endfunction

    // Result is {overflow, negative, magnitude[9:0]}; range checked on the full word.
    function automatic logic [11:0] classify(input logic [DATA_WIDTH-1:0] v);
        logic signed [DATA_WIDTH:0] sv;
        logic signed [DATA_WIDTH:0] av;
        sv = {(SIGNED_MODE ? v[DATA_WIDTH-1] : 1'b0), v};
        av = sv[DATA_WIDTH] ? -sv : sv;
        classify = {((sv > MAX_VAL) || (sv < MIN_VAL)), sv[DATA_WIDTH], av[9:0]};
    endfunction

    function automatic logic [21:0] dabble_step(input logic [21:0] s);
        logic [21:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[10+4*i +: 4] >= 4'd5)
                t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
        end
        dabble_step = {t[20:0], 1'b0};
    endfunction

    function automatic logic [20:0] fmt_digits(input logic o, input logic n,
                                               input logic [11:0] bcd);
        logic [3:0] h, t, u;
        h = bcd[11:8];
        t = bcd[7:4];
        u = bcd[3:0];
        if (o)
            fmt_digits = {SEG_E, SEG_E, SEG_E};
        else if (n && (h != 4'd0 || t != 4'd0))
            fmt_digits = {SEG_MINUS, digit_seg(t), digit_seg(u)};
        else if (n)
            fmt_digits = {SEG_BLANK, SEG_MINUS, digit_seg(u)};
        else
            fmt_digits = {((h == 4'd0) ? SEG_BLANK : digit_seg(h)),
                          ((h == 4'd0 && t == 4'd0) ? SEG_BLANK : digit_seg(t)),
                          digit_seg(u)};
    endfunction

    // A pending word always takes precedence over a strobe seen in IDLE.
    assign start_word = pend_vld ? pend_data : data;
    assign cls        = classify(start_word);
    assign to_pend    = out_strobe && ((state != IDLE) || pend_vld);
    assign busy       = (state != IDLE) || pend_vld;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (pend_vld || out_strobe) begin
                    start     = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (iter_cnt == 4'd9)
                    state_nxt = UPDATE;
            end
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            iter_cnt <= 4'd0;
            pend_vld <= 1'b0;
            outputA  <= SEG_BLANK;
            outputB  <= SEG_BLANK;
            outputC  <= SEG_ZERO;
        end else begin
            state <= state_nxt;
            if (state == SHIFT)
                iter_cnt <= (iter_cnt == 4'd9) ? 4'd0 : iter_cnt + 4'd1;
            else
                iter_cnt <= 4'd0;
            if (to_pend)
                pend_vld <= 1'b1;
            else if (start)
                pend_vld <= 1'b0;
            if (state == UPDATE)
                {outputA, outputB, outputC} <= fmt_digits(ovf, neg, sr[21:10]);
        end
    end

    // Datapath registers carry no reset; they are always loaded before use.
    always_ff @(posedge clock) begin
        if (to_pend)
            pend_data <= data;
        if (start) begin
            sr  <= {12'd0, cls[9:0]};
            neg <= cls[10];
            ovf <= cls[11];
        end else if (state == SHIFT) begin
            sr <= dabble_step(sr);
        end
    end

endmodule

// File: tb/tb_seg7_display_unit.sv
// Bench for seg7_display_unit: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level decimal display model.
module tb_seg7_display_unit;

    logic        clock;
    logic        reset;
    logic        out_strobe;
    logic [31:0] data;
    logic        busy;
    logic [6:0]  outputA, outputB, outputC;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MI = 7'b0111111;
    localparam logic [6:0] EE = 7'b0000110;
    logic [6:0] seg_tbl [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    seg7_display_unit #(.DATA_WIDTH(32), .SIGNED_MODE(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .out_strobe (out_strobe),
        .data       (data),
        .busy       (busy),
        .outputA    (outputA),
        .outputB    (outputB),
        .outputC    (outputC)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Display expected for a word, from decimal arithmetic on its signed value.
    function automatic logic [20:0] expect_disp(input logic [31:0] w);
        longint v;
        longint m;
        longint h, t, u;
        v = $signed(w);
        if (v > 999 || v < -99)
            return {EE, EE, EE};
        if (v < 0) begin
            m = -v;
            if (m >= 10)
                return {MI, seg_tbl[m/10], seg_tbl[m%10]};
            return {BL, MI, seg_tbl[m]};
        end
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        return {((h == 0) ? BL : seg_tbl[h]),
                ((h == 0 && t == 0) ? BL : seg_tbl[t]),
                seg_tbl[u]};
    endfunction

    // Model: a result lands 11 edges after the word is taken; one-entry latest-wins buffer.
    int          m_timer = 0;
    logic [31:0] m_word;
    logic [31:0] m_pend;
    bit          m_pend_vld = 0;
    logic [6:0]  m_a, m_b, m_c;

    always @(posedge clock) begin
        if (!reset) begin
            m_timer    = 0;
            m_pend_vld = 0;
            m_a = BL; m_b = BL; m_c = seg_tbl[0];
        end else if (m_timer == 0) begin
            if (m_pend_vld) begin
                m_word  = m_pend;
                m_timer = 11;
                if (out_strobe) m_pend = data;
                else m_pend_vld = 0;
            end else if (out_strobe) begin
                m_word  = data;
                m_timer = 11;
            end
        end else begin
            if (out_strobe) begin
                m_pend     = data;
                m_pend_vld = 1;
            end
            m_timer--;
            if (m_timer == 0)
                {m_a, m_b, m_c} = expect_disp(m_word);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_busy", {6'd0, busy}, {6'd0, (m_timer != 0) || m_pend_vld});
            chk("model_A", outputA, m_a);
            chk("model_B", outputB, m_b);
            chk("model_C", outputC, m_c);
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_busy(input int n);
        repeat (n) begin
            @(negedge clock);
            chk("busy_held", {6'd0, busy}, 7'd1);
        end
    endtask

    task automatic strobe(input logic [31:0] v);
        out_strobe = 1'b1;
        data       = v;
        @(negedge clock);
        out_strobe = 1'b0;
    endtask

    task automatic chk_disp(input string name, input logic [6:0] a,
                            input logic [6:0] b, input logic [6:0] c);
        chk({name, "_A"}, outputA, a);
        chk({name, "_B"}, outputB, b);
        chk({name, "_C"}, outputC, c);
    endtask

    logic [31:0] specials [0:10] = '{32'd999, 32'd1000, 32'hFFFFFF9D, 32'hFFFFFF9C,
                                     32'd0, 32'd9, 32'd10, 32'hFFFFFFF7, 32'hFFFFFFF6,
                                     32'h80000000, 32'h7FFFFFFF};

    initial begin
        reset      = 1'b0;
        out_strobe = 1'b0;
        data       = 32'd0;
        wait_n(2);
        chk_en = 1;
        reset  = 1'b1;

        wait_n(3);
        chk_disp("reset", BL, BL, 7'b1000000);
        chk("reset_busy", {6'd0, busy}, 7'd0);

        strobe(32'd999);
        wait_busy(10);
        chk_disp("pre999", BL, BL, 7'b1000000);
        wait_n(1);
        chk_disp("d999", 7'b0010000, 7'b0010000, 7'b0010000);
        chk("busy_fall", {6'd0, busy}, 7'd0);

        strobe(32'd7);
        strobe(32'hFFFFFFD6);
        wait_n(10);
        chk_disp("d7", BL, BL, 7'b1111000);
        wait_n(12);
        chk_disp("dm42", 7'b0111111, 7'b0011001, 7'b0100100);

        strobe(32'hFFFFFFFB);
        wait_n(11);
        chk_disp("dm5", BL, MI, 7'b0010010);
        strobe(32'd1000);
        wait_n(11);
        chk_disp("d1000", EE, EE, EE);
        strobe(32'd5);
        wait_n(11);
        strobe(32'h80000000);
        wait_n(11);
        chk_disp("dmin", EE, EE, EE);

        strobe(32'd12);
        wait_busy(2);
        strobe(32'd34);
        wait_busy(1);
        strobe(32'd56);
        wait_busy(5);
        wait_n(1);
        chk_disp("d12", BL, 7'b1111001, 7'b0100100);
        chk("busy_e11", {6'd0, busy}, 7'd1);
        wait_busy(11);
        wait_n(1);
        chk_disp("d56", BL, 7'b0010010, 7'b0000010);
        chk("busy_e23", {6'd0, busy}, 7'd0);

        strobe(32'd500);
        wait_n(5);
        reset = 1'b0;
        wait_n(1);
        reset = 1'b1;
        chk_disp("abort", BL, BL, 7'b1000000);
        chk("abort_busy", {6'd0, busy}, 7'd0);
        wait_n(5);
        chk_disp("no_late", BL, BL, 7'b1000000);
        strobe(32'd8);
        wait_n(11);
        chk_disp("d8", BL, BL, 7'b0000000);

        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 499) != 0);
            out_strobe = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       data = $urandom_range(0, 1100);
                1:       data = 32'(-int'($urandom_range(0, 150)));
                2:       data = $urandom;
                default: data = specials[$urandom_range(0, 10)];
            endcase
            @(negedge clock);
        end
        reset      = 1'b1;
        out_strobe = 1'b0;
        wait_n(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_display_unit.md
# seg7_display_unit

Output stage of the CPU: consumes the register value the control unit emits on an output instruction and drives the three seven-segment displays (outputA/B/C). A sequential double-dabble converter turns the 32-bit two's-complement word into up to three decimal digits with leading-zero blanking, a minus sign, and an overflow indication. A one-deep pending buffer absorbs a new strobe that arrives while a conversion is running.

## Interface

- DATA_WIDTH, 32, width of the input word.
- SIGNED_MODE, 1, 1 = data is two's complement; 0 = unsigned.

Ports:

- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- out_strobe  in  1  one-cycle request from the control unit; data is valid in the same cycle.
- data  in  DATA_WIDTH  value to display, taken from register data1.
- busy  out  1  high while a conversion or pending request is outstanding.
- outputA  out  7  hundreds digit, leftmost display.
- outputB  out  7  tens digit.
- outputC  out  7  units digit.

## Operation

- Segments are active-low, with bit6..bit0 = g,f,e,d,c,b,a.
- Digit patterns:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, minus=0111111, E=0000110
- States:
  - IDLE, SHIFT, UPDATE.
  - IDLE: on strobe (or pending valid), capture the word, classify it, go to SHIFT with the iteration counter at 0.
  - SHIFT: 10 iterations, one per cycle. Each iteration adds 3 to any BCD nibble ≥5, then shifts {bcd[11:0], mag[9:0]} left by 1. After iteration 9, go to UPDATE.
  - UPDATE: load the display registers and go to IDLE.
- Classification, done at capture on the full-width value:
  - Overflow if the value is >999, or <−99 when SIGNED_MODE=1. This includes the most-negative value; no abs() wrap is relied on.
  - Otherwise mag = |value|[9:0] and neg = sign bit (SIGNED_MODE=1 only).
- Overflow still runs the 10 SHIFT cycles (fixed latency). UPDATE then shows E,E,E.
- Formatting at UPDATE, with H/T/U the BCD digits:
  - Non-negative: H blank if 0. T blank if H and T are both 0. U always shown.
  - Negative, mag ≥10: outputA=minus, B=T, C=U.
  - Negative, mag <10: A=blank, B=minus, C=U.
- Pending buffer, one entry:
  - A strobe while state≠IDLE latches data into pending and sets pending_valid. A later strobe overwrites it (latest wins).
  - When UPDATE goes to IDLE with pending_valid set, the next cycle starts the pending word exactly as a fresh strobe would, and clears pending_valid.
- Strobe in IDLE with pending_valid=0: the strobe data is used directly.
- Strobe in the same cycle as UPDATE: the word goes to pending. It does not displace the result being committed.
- busy = (state≠IDLE) | pending_valid.
- The display registers are only written in UPDATE. They hold their value indefinitely otherwise.

## Timing

- Reset (reset=0 at an edge):
  - state=IDLE, counter=0, pending_valid=0, busy=0.
  - outputA=blank, outputB=blank, outputC=0 (shows "  0").
  - Reset takes priority over every other event. Reset mid-conversion aborts it, discards pending, and restores the reset display.
- Latency: strobe sampled in IDLE at edge E0. SHIFT iterations occur at E1..E10. Displays change at E11. busy rises after E0 and falls after E11 if nothing is pending.
- Back-to-back requests: the pending word is captured at E12 and displayed at E23.
- Throughput: one result per 12 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Reset, then 3 idle cycles: A/B/C = 1111111, 1111111, 1000000; busy=0.
- Strobe data=0x000003E7 (999): busy high for 11 cycles; at E11 A/B/C = 0010000, 0010000, 0010000.
- Strobe data=7, then data=−42 after it: first shows blank,blank,1111000. Second shows 0111111, 0011001, 0100100.
- Strobe −5, then 1000, then 0x80000000 (most negative): −5 shows blank,minus,0010010. 1000 shows E,E,E. 0x80000000 shows E,E,E.
- Strobe 12 at E0, strobe 34 at E3, strobe 56 at E5:
  - At E11 shows "12" (blank, 1111001, 0100100).
  - At E23 shows "56"; 34 is overwritten and never displayed.
  - busy stays high from E1 through E23.
- Strobe 500, assert reset at E6: outputs return to the reset pattern, busy=0, and no late update at E11. A strobe of 8 after reset shows "  8" 11 edges later.
